serial_pattern_gen: RTL and testbench
=====================================

// Module: serial_pattern_gen
// PURPOSE
//   Programmable serial bit-stream generator: the transmit end of the 1-bit serial link consumed by the
//   lab sequence detectors (Mealy/Moore, input j, output w). Loads a pattern word and shifts it out
//   MSB-first, one bit per clock, optionally repeated. Replaces hand-written j stimulus in benches and
//   drives detectors in on-board demos.
// PARAMETERS
//   W       8   pattern register width (bits)
//   REP_W   4   width of repeat-count input
//   GAP_LEN 2   idle-zero bits between repetitions (used only when PATGEN_GAP_EN is defined)
// PORTS
//   clock    in   1                 system clock, rising edge
//   reset    in   1                 asynchronous, active-high reset
//   start    in   1                 request: sampled only in IDLE
//   abort    in   1                 synchronous cancel of a running stream
//   pattern  in   W                 bits to send; bit len-1 is sent first
//   len      in   $clog2(W+1)       number of pattern bits to send
//   reps     in   REP_W             number of repetitions (0 treated as 1)
//   j        out  1                 serial data, registered
//   busy     out  1                 high while a stream is in progress
//   done     out  1                 one-cycle pulse after the last bit of the last repetition
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high. Reset (any time, incl. mid-stream):
//     state=IDLE, j=0, busy=0, done=0, all counters 0.
//   - FSM states: IDLE, SHIFT, GAP, DONE.
//   - IDLE: j=0. start=1 with len!=0 -> capture pattern/len/reps, go SHIFT; len>W clamped to W.
//     start with len==0 ignored (no busy, no done).
//   - Latency: first bit on j in the cycle after the start edge; busy rises in that same cycle.
//   - SHIFT: j = pattern[bit_idx], bit_idx counts len-1 down to 0, one bit per cycle.
//     After bit 0: if reps remaining > 1 -> GAP (macro on) or reload bit_idx=len-1 with no bubble (macro off);
//     else -> DONE.
//   - GAP: j=0 for exactly GAP_LEN cycles, busy stays 1, then SHIFT at bit len-1.
//   - DONE: j=0, busy=0, done=1 for exactly one cycle, then IDLE. A new start is accepted in the
//     cycle after DONE (start during DONE is ignored).
//   - start while busy: ignored; captured registers are not disturbed by input changes.
//   - abort=1 in SHIFT/GAP: next cycle IDLE, j=0, busy=0, no done pulse. abort in IDLE/DONE: no effect.
//   - Simultaneous start+abort in IDLE: start wins.
//   - Repeat counter width REP_W; reps=2^REP_W-1 must not wrap.
//   - Total busy cycles = R*L + (R-1)*GAP_LEN (macro on) or R*L (macro off), where L = clamped len
//     and R = max(reps,1).
// CONFIGURATION
//   PATGEN_GAP_EN defined: GAP state present; GAP_LEN zeros inserted between repetitions.
//   PATGEN_GAP_EN undefined: GAP state and its counter compiled out; repetitions are back-to-back,
//   and GAP_LEN is ignored.
// STRUCTURE
//   Package serial_pattern_pkg: state_t enum {IDLE,SHIFT,GAP,DONE}, default widths, and the
//   clamp_len() function.
//   Sub-module piso_shreg: W-bit parallel-load, shift-left register with load/shift enables and
//   an async reset. The top level holds the FSM, bit counter, repeat counter and gap counter.
// TESTING
//   1. pattern=8'b0000_1001, len=4, reps=1, start 1 cycle -> j=1,0,0,1 on cycles 1-4; done=1 on cycle 5;
//      busy high on cycles 1-4 only.
//   2. pattern=3'b100, len=3, reps=3, macro off -> j=100100100 over 9 cycles, with no bubble, then done.
//   3. Same as 2 with PATGEN_GAP_EN and GAP_LEN=2 -> j=100 00 100 00 100; busy for 13 cycles.
//   4. abort asserted on the 3rd bit of a len=8 stream -> j=0 and busy=0 from the next cycle; done never pulses.
//   5. reset pulsed mid-stream (asynchronously, between edges) -> j, busy and done drop immediately.
//      After release, start with len=0 -> stays IDLE.
//   6. Loopback: j feeds the sequence detector with patterns 1001 and 100. Detector w asserts exactly
//      at the golden-model cycles. Also apply start while busy and confirm the stream is unchanged.

Source files
------------

// File: rtl/serial_pattern_pkg.sv
// Shared types and helpers for the serial pattern generator.
// State encoding, default widths and the pattern-length clamp.
package serial_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    localparam int DEF_W       = 8;
    localparam int DEF_REP_W   = 4;
    localparam int DEF_GAP_LEN = 2;

    // Requests longer than the pattern register are truncated to the register width.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned w);
        return (len > w) ? w : len;
    endfunction

endpackage

// File: rtl/serial_pattern_gen_piso_shreg.sv
// W-bit parallel-in serial-out register: parallel load or shift-left by one, load has priority.
module piso_shreg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial bit-stream generator: shifts a captured pattern out MSB-first on j, optionally repeated.
// Define PATGEN_GAP_EN to insert GAP_LEN idle-zero bits between repetitions.
module serial_pattern_gen
    import serial_pattern_pkg::*;
#(
    parameter  int W       = DEF_W,
    parameter  int REP_W   = DEF_REP_W,
    parameter  int GAP_LEN = DEF_GAP_LEN,
    localparam int LEN_W   = $clog2(W + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    output logic             j,
    output logic             busy,
    output logic             done
);

    state_t             state, next_state;
    logic [W-1:0]       pat_q;
    logic [LEN_W-1:0]   len_q, bit_idx, bit_idx_n;
    logic [REP_W-1:0]   rep_cnt, rep_cnt_n;
    logic [LEN_W-1:0]   in_len;
    logic [W-1:0]       in_aligned;
    logic [W-1:0]       sh_q, sh_din;
    logic               sh_load, sh_shift;
    logic               capture, reload;
    logic               j_next;

`ifdef PATGEN_GAP_EN
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
`else
    logic               unused_gap;
    assign unused_gap = ^GAP_LEN;
`endif

    // Left-justify the request so bit len-1 sits at the MSB of the shift register.
    assign in_len     = LEN_W'(clamp_len(32'(len), 32'(W)));
    assign in_aligned = pattern << (W - int'(in_len));

    // The register holds the bits still to come; the bit currently on j lives in the j flop.
    piso_shreg #(.W(W)) u_shreg (
        .clock (clock),
        .reset (reset),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .q     (sh_q)
    );

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        reload     = 1'b0;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        sh_din     = '0;
        j_next     = 1'b0;
        bit_idx_n  = bit_idx;
        rep_cnt_n  = rep_cnt;
`ifdef PATGEN_GAP_EN
        gap_cnt_n  = gap_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (start && len != '0) begin
                    next_state = SHIFT;
                    capture    = 1'b1;
                    sh_load    = 1'b1;
                    sh_din     = in_aligned << 1;
                    j_next     = in_aligned[W-1];
                    bit_idx_n  = in_len - LEN_W'(1);
                    rep_cnt_n  = (reps == '0) ? REP_W'(1) : reps;
                end
            end
            SHIFT: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (bit_idx != '0) begin
                    sh_shift  = 1'b1;
                    j_next    = sh_q[W-1];
                    bit_idx_n = bit_idx - LEN_W'(1);
                end else if (rep_cnt > REP_W'(1)) begin
                    rep_cnt_n = rep_cnt - REP_W'(1);
`ifdef PATGEN_GAP_EN
                    if (GAP_LEN == 0) begin
                        reload = 1'b1;
                    end else begin
                        next_state = GAP;
                        gap_cnt_n  = GAP_W'(GAP_LEN - 1);
                    end
`else
                    reload = 1'b1;
`endif
                end else begin
                    next_state = DONE;
                end
            end
            GAP: begin
`ifdef PATGEN_GAP_EN
                if (abort) begin
                    next_state = IDLE;
                end else if (gap_cnt == '0) begin
                    next_state = SHIFT;
                    reload     = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt - GAP_W'(1);
                end
`else
                next_state = IDLE;
`endif
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase

        if (reload) begin
            sh_load   = 1'b1;
            sh_din    = pat_q << 1;
            j_next    = pat_q[W-1];
            bit_idx_n = len_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            bit_idx <= '0;
            rep_cnt <= '0;
            j       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= next_state;
            bit_idx <= bit_idx_n;
            rep_cnt <= rep_cnt_n;
            j       <= j_next;
            busy    <= (next_state == SHIFT) || (next_state == GAP);
            done    <= (next_state == DONE);
            if (capture) begin
                pat_q <= in_aligned;
                len_q <= in_len;
            end
        end
    end

`ifdef PATGEN_GAP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench for serial_pattern_gen with a loopback 1001 detector on j.
// Honours PATGEN_GAP_EN when building the expected streams.
module tb_serial_pattern_gen;
    import serial_pattern_pkg::*;

    localparam int W       = 8;
    localparam int REP_W   = 4;
    localparam int GAP_LEN = 2;
    localparam int LEN_W   = $clog2(W + 1);
`ifdef PATGEN_GAP_EN
    localparam int GAPS = GAP_LEN;
`else
    localparam int GAPS = 0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [W-1:0]     pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] reps;
    logic             j;
    logic             busy;
    logic             done;

    serial_pattern_gen #(.W(W), .REP_W(REP_W), .GAP_LEN(GAP_LEN)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .j       (j),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    // Loopback consumer: Moore-style detector for 1001 on the serial line.
    logic [3:0] det_hist;
    logic       w;
    always @(posedge clock or posedge reset) begin
        if (reset) det_hist <= '0;
        else       det_hist <= {det_hist[2:0], j};
    end
    assign w = (det_hist == 4'b1001);

    typedef struct packed {
        logic j;
        logic busy;
        logic done;
        logic w;
    } obs_t;

    obs_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] model_hist;

    task automatic push_exp(input logic ej, input logic eb, input logic ed);
        obs_t e;
        e.j    = ej;
        e.busy = eb;
        e.done = ed;
        e.w    = (model_hist == 4'b1001);
        model_hist = {model_hist[2:0], ej};
        sb.push_back(e);
    endtask

    task automatic check_next(input string tag);
        obs_t exp_v, got;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
            return;
        end
        exp_v = sb.pop_front();
        got   = {j, busy, done, w};
        assert (got === exp_v) else begin
            errors++;
            $error("FAIL %s: j/busy/done/w observed=%b expected=%b", tag, got, exp_v);
        end
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        abort = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic run_stream(input string tag, input logic [W-1:0] pat, input int ln,
                              input int rp, input int abort_at, input int busy_start_at,
                              input bit start_in_done, input bit with_abort);
        int   lc, rc;
        logic bits[$];
        idle(4);
        model_hist = '0;
        lc = (ln > W) ? W : ln;
        rc = (rp == 0) ? 1 : rp;
        for (int r = 0; r < rc; r++) begin
            for (int i = lc - 1; i >= 0; i--) bits.push_back(pat[i]);
            if (r < rc - 1) repeat (GAPS) bits.push_back(1'b0);
        end
        if (abort_at > 0) while (bits.size() > abort_at) void'(bits.pop_back());
        foreach (bits[i]) push_exp(bits[i], 1'b1, 1'b0);
        if (abort_at == 0) push_exp(1'b0, 1'b0, 1'b1);
        repeat (3) push_exp(1'b0, 1'b0, 1'b0);

        pattern = pat;
        len     = LEN_W'(ln);
        reps    = REP_W'(rp);
        start   = 1'b1;
        abort   = with_abort;
        @(posedge clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int k = 1; sb.size() > 0; k++) begin
            logic is_done;
            is_done = sb[0].done;
            check_next(tag);
            start = (k == busy_start_at) || (start_in_done && is_done);
            abort = (k == abort_at);
            if (k == busy_start_at) begin
                pattern = ~pat;
                len     = LEN_W'(1);
                reps    = '1;
            end
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        model_hist = '0;
        #1;
        push_exp(1'b0, 1'b0, 1'b0);
        check_next("reset_state");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        run_stream("single_1001",      8'b0000_1001, 4,  1,  0, 0, 1'b0, 1'b0);
        run_stream("rep3_100",         8'b0000_0100, 3,  3,  0, 0, 1'b0, 1'b0);
        run_stream("loop_1001_busy_start", 8'b0000_1001, 4, 2, 0, 2, 1'b0, 1'b0);
        run_stream("len_clamp",        8'hA5,        12, 1,  0, 0, 1'b0, 1'b0);
        run_stream("reps_zero",        8'b0000_0010, 2,  0,  0, 0, 1'b0, 1'b0);
        run_stream("reps_max",         8'b0000_0001, 1,  15, 0, 0, 1'b0, 1'b0);
        run_stream("abort_bit3",       8'b1011_0110, 8,  1,  3, 0, 1'b0, 1'b0);
        run_stream("abort_rep_edge",   8'b0000_0101, 3,  2,  4, 0, 1'b0, 1'b0);
        run_stream("start_abort_idle", 8'b0000_1101, 4,  1,  0, 0, 1'b0, 1'b1);
        run_stream("start_in_done",    8'b0000_0011, 2,  1,  0, 0, 1'b1, 1'b0);

        // Asynchronous reset between edges in the middle of a stream.
        idle(4);
        pattern = 8'hFF;
        len     = LEN_W'(8);
        reps    = REP_W'(1);
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        model_hist = '0;
        push_exp(1'b0, 1'b0, 1'b0);
        check_next("reset_midstream");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // len==0 request is ignored.
        model_hist = '0;
        repeat (4) push_exp(1'b0, 1'b0, 1'b0);
        pattern = 8'hFF;
        len     = '0;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        while (sb.size() > 0) begin
            check_next("len_zero");
            @(posedge clock);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
